// File: rtl/tape_recorder.sv
// Oric cassette recorder: decodes the K7 tape output waveform (one cycle per bit,
// short = 1, long = 0) into framed bytes and writes them into the tape cache.
module tape_recorder #(
  parameter int unsigned US_DIV       = 24,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned MIN_US       = 100,
  parameter int unsigned SHORT_MAX_US = 312,
  parameter int unsigned LONG_MAX_US  = 624
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clear,
  input  logic              tape_out_in,
  output logic              tape_wr,
  output logic [ADDR_W-1:0] tape_addr,
  output logic [7:0]        tape_dout,
  output logic [ADDR_W:0]   tape_len,
  output logic              full,
  output logic [7:0]        err_cnt,
  output logic              active
);

  localparam int unsigned PRE_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned PER_SAT = LONG_MAX_US + 1;
  localparam int unsigned PER_W   = $clog2(PER_SAT + 1);

  typedef enum logic [1:0] {S_HUNT, S_DATA, S_PARITY, S_STOP} state_t;

  logic             sync1, sync2, sync2_d;
  logic [PRE_W-1:0] presc;
  logic [PER_W-1:0] per;
  logic             edge_c, accept_c, gap_c, one_c, tick_c, timeout_c;
  logic             bit_vld, bit_val, gap_q;

  state_t           state, state_nxt;
  logic [7:0]       sr, sr_nxt;
  logic [2:0]       bitcnt, bitcnt_nxt;
  logic [7:0]       err_nxt;
  logic [ADDR_W:0]  ptr, ptr_nxt;
  logic             wr_c, err_inc_c, wr_fire_c;

  // Input synchronizer and rising-edge history; runs regardless of en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= tape_out_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // Edge classification against the measured period
  always_comb begin
    edge_c    = en & sync2 & ~sync2_d;
    accept_c  = edge_c && (per >= PER_W'(MIN_US));
    gap_c     = per > PER_W'(LONG_MAX_US);
    one_c     = per <= PER_W'(SHORT_MAX_US);
    tick_c    = presc == PRE_W'(US_DIV - 1);
    timeout_c = (per == PER_W'(PER_SAT)) && !edge_c;
  end

  // Microsecond prescaler and saturating period counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      per   <= '0;
    end else if (!en || clear || accept_c) begin
      presc <= '0;
      per   <= '0;
    end else if (tick_c) begin
      presc <= '0;
      if (per != PER_W'(PER_SAT)) per <= per + PER_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Registered bit / gap events feeding the framer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_vld <= 1'b0;
      bit_val <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      bit_vld <= accept_c && !gap_c && !clear;
      bit_val <= one_c;
      gap_q   <= accept_c && gap_c && !clear;
    end
  end

  // Framer next-state, write request and error accounting
  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    bitcnt_nxt = bitcnt;
    wr_c       = 1'b0;
    err_inc_c  = 1'b0;

    if (bit_vld) begin
      unique case (state)
        S_HUNT: begin
          if (!bit_val) begin
            state_nxt  = S_DATA;
            bitcnt_nxt = '0;
          end
        end
        S_DATA: begin
          sr_nxt     = {bit_val, sr[7:1]};
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          wr_c      = 1'b1;
          err_inc_c = (^sr) == bit_val;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          if (bit_val) begin
            state_nxt = S_HUNT;
          end else begin
            err_inc_c  = 1'b1;
            state_nxt  = S_DATA;
            bitcnt_nxt = '0;
          end
        end
        default: state_nxt = S_HUNT;
      endcase
    end

    if (gap_q || timeout_c || !en || clear) state_nxt = S_HUNT;

    wr_fire_c = wr_c && en && !clear && !ptr[ADDR_W];

    if (clear) begin
      err_nxt = '0;
    end else if (err_inc_c && en && (err_cnt != 8'hFF)) begin
      err_nxt = err_cnt + 8'd1;
    end else begin
      err_nxt = err_cnt;
    end

    if (clear) begin
      ptr_nxt = '0;
    end else if (tape_wr) begin
      ptr_nxt = ptr + (ADDR_W + 1)'(1);
    end else begin
      ptr_nxt = ptr;
    end
  end

  // Framer state, write port and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_HUNT;
      sr        <= '0;
      bitcnt    <= '0;
      err_cnt   <= '0;
      ptr       <= '0;
      tape_wr   <= 1'b0;
      tape_addr <= '0;
      tape_dout <= '0;
      active    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      bitcnt  <= bitcnt_nxt;
      err_cnt <= err_nxt;
      ptr     <= ptr_nxt;
      tape_wr <= wr_fire_c;
      if (wr_fire_c) begin
        tape_addr <= ptr[ADDR_W-1:0];
        tape_dout <= sr;
      end
      active  <= state_nxt != S_HUNT;
    end
  end

  assign tape_len = ptr;
  assign full     = ptr[ADDR_W];

endmodule

// File: tb/tb_tape_recorder.sv
// Scoreboard bench for tape_recorder: builds bit-period streams, decodes them with a
// list-scanning reference decoder, and checks every cache write as it appears.
module tb_tape_recorder;

  localparam int unsigned US_DIV       = 2;
  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned MIN_US       = 20;
  localparam int unsigned SHORT_MAX_US = 62;
  localparam int unsigned LONG_MAX_US  = 125;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ONE_US  = 42;
  localparam int ZERO_US = 83;
  localparam int GAP_US  = 160;
  localparam int IDLE_US = 200;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic              clear = 1'b0;
  logic              tape_out_in = 1'b0;
  logic              tape_wr;
  logic [ADDR_W-1:0] tape_addr;
  logic [7:0]        tape_dout;
  logic [ADDR_W:0]   tape_len;
  logic              full;
  logic [7:0]        err_cnt;
  logic              active;

  tape_recorder #(
    .US_DIV(US_DIV), .ADDR_W(ADDR_W), .MIN_US(MIN_US),
    .SHORT_MAX_US(SHORT_MAX_US), .LONG_MAX_US(LONG_MAX_US)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear),
    .tape_out_in(tape_out_in), .tape_wr(tape_wr), .tape_addr(tape_addr),
    .tape_dout(tape_dout), .tape_len(tape_len), .full(full),
    .err_cnt(err_cnt), .active(active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  per_q[$];
  bit  gl_q[$];
  int  edge_cyc[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  m_ptr = 0;
  int  m_err = 0;
  int  last_wr_cyc = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard
  always @(negedge clk) begin
    if (reset_n && tape_wr) begin
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%02h, none expected", tape_addr, tape_dout);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(tape_addr), e.addr);
        chk("wr_data", int'(tape_dout), e.data);
      end
    end
  end

  function automatic int jit(int base);
    return base - 4 + int'($urandom_range(8));
  endfunction

  // b: 1 = short cycle, 0 = long cycle, 2 = gap
  task automatic add_bit(int b, bit gl = 1'b0);
    per_q.push_back(b == 1 ? jit(ONE_US) : (b == 0 ? jit(ZERO_US) : GAP_US));
    gl_q.push_back(gl);
  endtask

  task automatic add_frame(int d, bit par_ok, int nstop, bit with_start = 1'b1, int gl_bit = -1);
    int p;
    if (with_start) add_bit(0);
    for (int k = 0; k < 8; k++) add_bit((d >> k) & 1, k == gl_bit);
    p = ($countones(d & 255) % 2 == 1) ? 0 : 1;
    if (!par_ok) p = 1 - p;
    add_bit(p);
    for (int k = 0; k < nstop; k++) add_bit(1);
  endtask

  // Reference decoder: scans the classified bit list frame by frame
  task automatic model_stream();
    int bits[$];
    int i;
    int nb;
    int d;
    int par;
    int s;
    foreach (per_q[k])
      bits.push_back(per_q[k] <= int'(SHORT_MAX_US) ? 1 : (per_q[k] <= int'(LONG_MAX_US) ? 0 : 2));
    i = 0;
    while (i < bits.size()) begin
      if (bits[i] != 0) begin
        i++;
        continue;
      end
      nb = 0;
      while (nb < 9 && i + 1 + nb < bits.size() && bits[i + 1 + nb] != 2) nb++;
      if (nb < 9) begin
        i = i + nb + 2;
        continue;
      end
      d = 0;
      for (int k = 0; k < 8; k++) if (bits[i + 1 + k] == 1) d |= (1 << k);
      par = bits[i + 9];
      if (m_ptr < DEPTH) begin
        exp_q.push_back('{addr: m_ptr, data: d});
        m_ptr++;
      end
      if (($countones(d) + par) % 2 == 0 && m_err < 255) m_err++;
      s = i + 10;
      if (s >= bits.size()) begin
        i = s;
      end else if (bits[s] == 0) begin
        if (m_err < 255) m_err++;
        i = s;
      end else begin
        i = s + 1;
      end
    end
  endtask

  // One waveform cycle: rising edge now, next rising edge us later
  task automatic emit(int us, bit gl);
    int total;
    total = us * int'(US_DIV);
    tape_out_in = 1'b1;
    edge_cyc.push_back(cyc + 1);
    if (gl) begin
      repeat (6) @(negedge clk);
      tape_out_in = 1'b0;
      repeat (14) @(negedge clk);
      tape_out_in = 1'b1;
      repeat (6) @(negedge clk);
      tape_out_in = 1'b0;
      repeat (total - 26) @(negedge clk);
    end else begin
      repeat (total / 2) @(negedge clk);
      tape_out_in = 1'b0;
      repeat (total - total / 2) @(negedge clk);
    end
  endtask

  task automatic run_stream(bit use_model);
    if (use_model) model_stream();
    tape_out_in = 1'b0;
    repeat (IDLE_US * int'(US_DIV)) @(negedge clk);
    edge_cyc.delete();
    foreach (per_q[k]) emit(per_q[k], gl_q[k]);
    emit(IDLE_US, 1'b0);
    per_q.delete();
    gl_q.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_ptr = 0;
    m_err = 0;
  endtask

  task automatic check_state(string tag);
    chk({tag, "_len"}, int'(tape_len), m_ptr);
    chk({tag, "_full"}, int'(full), (m_ptr == DEPTH) ? 1 : 0);
    chk({tag, "_err"}, int'(err_cnt), m_err);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_wr"}, int'(tape_wr), 0);
    chk({tag, "_addr"}, int'(tape_addr), 0);
    chk({tag, "_dout"}, int'(tape_dout), 0);
    chk({tag, "_len"}, int'(tape_len), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
    chk({tag, "_active"}, int'(active), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    en = 1'b1;

    // 0x55 with good parity and two stops, plus write latency
    add_frame(8'h55, 1'b1, 2);
    run_stream(1'b1);
    check_state("b55");
    chk("latency", last_wr_cyc - edge_cyc[10], 3);

    // 0x55 with bad parity: still written, one error
    do_clear();
    add_frame(8'h55, 1'b0, 2);
    run_stream(1'b1);
    check_state("b55bad");

    // 0x00 then 0xFF back-to-back, single stop
    do_clear();
    add_frame(8'h00, 1'b1, 1);
    add_frame(8'hFF, 1'b1, 1);
    run_stream(1'b1);
    check_state("b00ff");

    // Gap after the 4th data bit, then a complete 0xA3
    do_clear();
    add_bit(0);
    add_bit(1); add_bit(0); add_bit(1); add_bit(1);
    add_bit(2);
    add_frame(8'hA3, 1'b1, 1);
    run_stream(1'b1);
    check_state("gap");

    // Glitch edge inside a data bit of 0x3C
    do_clear();
    add_frame(8'h3C, 1'b1, 1, 1'b1, 3);
    run_stream(1'b1);
    check_state("glitch");

    // Stop bit 0 reused as the start of the next byte
    do_clear();
    add_frame(8'h12, 1'b1, 0);
    add_bit(0);
    add_frame(8'h9A, 1'b1, 1, 1'b0);
    run_stream(1'b1);
    check_state("stop0");

    // Reset mid-frame clears every output immediately
    tape_out_in = 1'b0;
    repeat (IDLE_US * int'(US_DIV)) @(negedge clk);
    emit(ZERO_US, 1'b0);
    emit(ONE_US, 1'b0);
    emit(ONE_US, 1'b0);
    chk("midframe_active", int'(active), 1);
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    m_ptr = 0;
    m_err = 0;
    @(negedge clk);
    tape_out_in = 1'b0;
    reset_n = 1'b1;

    // Randomized frames
    for (int r = 0; r < 2; r++) begin
      do_clear();
      for (int f = 0; f < 3; f++)
        add_frame(int'($urandom_range(255)), $urandom_range(3) != 0, 1 + int'($urandom_range(1)));
      run_stream(1'b1);
      check_state($sformatf("rnd%0d", r));
    end

    // en low: no decoding, status retained
    en = 1'b0;
    add_frame(8'h5A, 1'b1, 1);
    run_stream(1'b0);
    check_state("en_off");
    en = 1'b1;

    // Fill the cache: five frames, only four stored
    do_clear();
    for (int f = 0; f < 5; f++)
      add_frame(int'($urandom_range(255)), 1'b1, 1);
    run_stream(1'b1);
    check_state("full");

    do_clear();
    repeat (2) @(negedge clk);
    check_state("clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tape_recorder.md
Name: tape_recorder

Overview:
- Decodes the Oric cassette output waveform (K7_TAPEOUT) into bytes and writes them into the tape cache RAM. It is the recording counterpart of the cassette playback block.
- Sits between the oricatmos core's tape output and the tapecache spram write port.
- Each bit is one waveform cycle: a short period is 1, a long period is 0.
- Frame format: start 0, 8 data bits LSB first, odd parity bit, one or more stop 1s.

Parameters:
- US_DIV, 24: clk cycles per microsecond tick.
- ADDR_W, 16: tape cache address width.
- MIN_US, 100: periods shorter than this are glitches.
- SHORT_MAX_US, 312: period <= this decodes as bit 1.
- LONG_MAX_US, 624: period <= this (and > SHORT_MAX_US) decodes as bit 0; longer is a gap.

Ports:
- clk, in, 1: system clock (clk_sys).
- reset_n, in, 1: asynchronous active-low reset.
- en, in, 1: recording enable (cassette relay AND record armed).
- clear, in, 1: synchronous restart of the recording at address 0.
- tape_out_in, in, 1: raw tape output from the core, asynchronous to clk.
- tape_wr, out, 1: one-cycle cache write strobe.
- tape_addr, out, ADDR_W: write address, valid while tape_wr is high.
- tape_dout, out, 8: byte to write, valid while tape_wr is high.
- tape_len, out, ADDR_W+1: number of bytes stored.
- full, out, 1: cache full, further writes suppressed.
- err_cnt, out, 8: saturating count of parity and framing errors.
- active, out, 1: high while the framer is not in HUNT.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0; pointer 0; framer HUNT; prescaler and period counter 0; synchronizers 0.
  - Deassertion is used directly; the instantiating level provides release synchronization.
- Input path:
  - 2-FF synchronizer, then rising-edge detect on the second flop.
  - An edge is "detected" in the cycle where sync2=1 and the previous sync2=0.
- Timebase:
  - Prescaler counts 0..US_DIV-1 and emits a tick on wrap.
  - Period counter increments per tick and saturates at LONG_MAX_US+1.
- On a detected edge, with p = period counter:
  - p < MIN_US: ignore the edge; counters keep running.
  - MIN_US <= p <= SHORT_MAX_US: bit=1.
  - p <= LONG_MAX_US: bit=0.
  - p > LONG_MAX_US: gap. Framer goes to HUNT, no bit is produced, no error is counted.
  - Any non-ignored edge zeroes the prescaler and period counter in the same cycle.
- Timeout: when the period counter saturates without an edge, the framer goes to HUNT. This does not count as an error.
- Framer:
  - HUNT: bit 0 goes to DATA with bitcnt=0. Bit 1 stays in HUNT.
  - DATA: sr <= {bit, sr[7:1]}. After the 8th bit, go to PARITY.
  - PARITY: issue a write of sr. If popcount(sr)+bit is even, err_cnt++ (saturating at 255). Go to STOP.
  - STOP: bit 1 goes to HUNT. Bit 0 is a framing error: err_cnt++, and the bit is treated as a start bit, so go to DATA with bitcnt=0.
- Write:
  - tape_wr is high for exactly one cycle, the cycle after the edge that delivered the parity bit.
  - During that cycle tape_addr = pointer[ADDR_W-1:0] and tape_dout = sr.
  - The pointer increments in the same cycle, so tape_len reflects the new count on the next cycle.
  - The byte is written even when its parity is bad.
- Latency: the first clk edge sampling tape_out_in=1 on the parity cycle is followed by tape_wr exactly 3 cycles later.
- Full:
  - full = pointer[ADDR_W].
  - When full, tape_wr is suppressed and the pointer holds. Decoding and err_cnt continue.
- en=0:
  - Framer is held in HUNT; prescaler and period counter are held at 0; no writes.
  - Pointer, tape_len, err_cnt and full are retained.
  - Edge detection resumes from the synchronizer state when en returns to 1.
- clear=1:
  - Pointer, err_cnt and full go to 0; framer to HUNT; counters to 0.
  - clear has priority: a write due in the same cycle is suppressed.
- Simultaneous timeout and edge in one cycle: edge classification wins.

Test Plan:
- Byte 0x55: send start(416us), 10101010 LSB-first, parity 1 (208us), two stops. Expect one tape_wr, tape_addr=0, tape_dout=0x55, tape_len=1, err_cnt=0, active back to 0.
- Same frame with parity bit 0. Expect the byte still written, err_cnt=1.
- Bytes 0x00, 0xFF back-to-back with one stop bit. Expect addr 0 -> 0x00 (parity 1), addr 1 -> 0xFF (parity 1), tape_len=2.
- Gap of 800us after the 4th data bit, then a full 0xA3 frame. Expect exactly one write, 0xA3, no error.
- Noise:
  - A 50us glitch edge injected mid-bit of a 0x3C frame: expect the glitch ignored and 0x3C written correctly.
  - A 0 in the stop position: expect err_cnt+1 and the next byte decoded from that start.
- Full and reset handling:
  - ADDR_W=2, 5 frames: expect 4 writes at addrs 0..3, full=1, tape_len=4, 5th frame produces no tape_wr.
  - clear pulse: expect tape_len=0, full=0.
  - reset_n low mid-frame: expect all outputs 0 immediately.
